rv64g_l1_bank_arbiter_rr: RTL
=============================

RV64G_L1_BANK_ARBITER_RR -- requirements
Module: rv64g_l1_bank_arbiter_rr

Interface
REQ-001 Parameter NUM_PORTS, 2, requester count (2..8); port 0 is the scalar port, ports 1..NUM_PORTS-1 are vector lanes.
REQ-002 Parameter TAG_W, 53, tag width.
REQ-003 Parameter INDEX_W, 5, set index width.
REQ-004 Parameter STARVE_LIMIT, 4, consecutive denied cycles before forced grant (1..255).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 req_i  in  NUM_PORTS  per-port access request.
REQ-009 we_i  in  NUM_PORTS  per-port data write.
REQ-010 index_i  in  NUM_PORTS*INDEX_W  per-port set index, port p at [p*INDEX_W +: INDEX_W].
REQ-011 word_i, way_i  in  NUM_PORTS*3 each  per-port word and way.
REQ-012 be_i  in  NUM_PORTS*8  per-port byte enables.
REQ-013 wdata_i  in  NUM_PORTS*64  per-port write data.
REQ-014 tag_we_i  in  1  scalar tag/state write (broadcast when req_i[0]=0).
REQ-015 tag_i  in  TAG_W; state_i  in  2  scalar tag and state.
REQ-016 gnt_o  out  NUM_PORTS  combinational one-hot grant, same cycle.
REQ-017 stall_o  out  NUM_PORTS  req_i & ~gnt_o.
REQ-018 bank_req_o, bank_we_o, bank_tag_we_o  out  1 each  registered bank command.
REQ-019 bank_index_o INDEX_W, bank_word_o 3, bank_way_o 3, bank_be_o 8, bank_wdata_o 64, bank_tag_o TAG_W, bank_state_o 2  out  registered bank fields.
REQ-020 starve_cnt_o  out  16  saturating count of forced grants.

Function
REQ-021 Broadcast = tag_we_i & ~req_i[0]; during broadcast gnt_o SHALL be all-zero and the bank command SHALL be a tag-only write (bank_tag_we_o=1, bank_we_o=0).
REQ-022 Per vector port p: wait_cnt[p] increments when req_i[p]&~gnt_o[p], saturates at STARVE_LIMIT, clears on grant or when req_i[p]=0.
REQ-023 Port p is starved when wait_cnt[p]==STARVE_LIMIT.
REQ-024 Grant priority, no broadcast: lowest-index starved port; else port 0 if requesting; else lowest-index requesting vector port.
REQ-025 A starved grant SHALL override a port-0 data request (port 0 stalls one cycle); it SHALL NOT override a broadcast; counters stay saturated through the broadcast.
REQ-026 A forced grant SHALL increment starve_cnt_o by 1, saturating at 0xFFFF.
REQ-027 Bank outputs SHALL register the granted port's fields one cycle after grant (latency 1); bank_req_o=1 on that cycle only.
REQ-028 tag_we_i with req_i[0]=1 SHALL be granted to port 0 as combined data+tag write when port 0 wins; if port 0 loses to a starved port, bank_tag_we_o=0 that cycle.
REQ-029 bank_tag_o/bank_state_o SHALL carry tag_i/state_i when port 0 or broadcast is selected, else zero.
REQ-030 With no grant and no broadcast, bank_req_o, bank_we_o and bank_tag_we_o SHALL be 0 next cycle; data fields hold.
REQ-031 Requesters SHALL hold req_i and fields until gnt_o; the block does not queue.

Reset
REQ-032 While rst_i=1: all registered bank outputs, wait_cnt and starve_cnt_o SHALL be 0, asynchronously; gnt_o SHALL be 0.
REQ-033 Reset assertion mid-wait SHALL discard counts; first grant after release follows REQ-024 from zero counts.

Verification (NUM_PORTS=2, STARVE_LIMIT=4)
REQ-034 req_i=2'b01, we_i=1, index=3, wdata=0xA5 -> gnt_o=01; next cycle bank_req_o=1, bank_we_o=1, bank_index_o=3, bank_wdata_o=0xA5.
REQ-035 req_i=2'b11 held -> gnt_o=01 cycles 0-3, gnt_o=10 cycle 4, starve_cnt_o=1 after cycle 4; cycle 5 gnt_o=01.
REQ-036 tag_we_i=1, req_i=2'b10, tag=0x1F -> gnt_o=00, stall_o=10; next cycle bank_tag_we_o=1, bank_we_o=0, bank_tag_o=0x1F.
REQ-037 Port 1 starved (4 denials) then broadcast 2 cycles -> gnt_o=00 both cycles, then gnt_o=10 first non-broadcast cycle.
REQ-038 rst_i pulsed after 3 denials of port 1 with req_i=11 -> outputs 0 during reset; after release port 1 granted at cycle 4, not earlier.

Source files
------------

// File: rtl/rv64g_l1_bank_arbiter_rr_if.sv
// Requester-side bundle for the L1 bank arbiter: per-port requests in, grants and the
// registered bank command out.
interface rv64g_l1_bank_arbiter_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 53,
  parameter int INDEX_W   = 5
);
  logic [NUM_PORTS-1:0]         req_i;
  logic [NUM_PORTS-1:0]         we_i;
  logic [NUM_PORTS*INDEX_W-1:0] index_i;
  logic [NUM_PORTS*3-1:0]       word_i;
  logic [NUM_PORTS*3-1:0]       way_i;
  logic [NUM_PORTS*8-1:0]       be_i;
  logic [NUM_PORTS*64-1:0]      wdata_i;
  logic                         tag_we_i;
  logic [TAG_W-1:0]             tag_i;
  logic [1:0]                   state_i;

  logic [NUM_PORTS-1:0]         gnt_o;
  logic [NUM_PORTS-1:0]         stall_o;
  logic                         bank_req_o;
  logic                         bank_we_o;
  logic                         bank_tag_we_o;
  logic [INDEX_W-1:0]           bank_index_o;
  logic [2:0]                   bank_word_o;
  logic [2:0]                   bank_way_o;
  logic [7:0]                   bank_be_o;
  logic [63:0]                  bank_wdata_o;
  logic [TAG_W-1:0]             bank_tag_o;
  logic [1:0]                   bank_state_o;
  logic [15:0]                  starve_cnt_o;

  modport slave (
    input  req_i, we_i, index_i, word_i, way_i, be_i, wdata_i, tag_we_i, tag_i, state_i,
    output gnt_o, stall_o, bank_req_o, bank_we_o, bank_tag_we_o, bank_index_o, bank_word_o,
           bank_way_o, bank_be_o, bank_wdata_o, bank_tag_o, bank_state_o, starve_cnt_o
  );
  modport master (
    output req_i, we_i, index_i, word_i, way_i, be_i, wdata_i, tag_we_i, tag_i, state_i,
    input  gnt_o, stall_o, bank_req_o, bank_we_o, bank_tag_we_o, bank_index_o, bank_word_o,
           bank_way_o, bank_be_o, bank_wdata_o, bank_tag_o, bank_state_o, starve_cnt_o
  );
endinterface

// File: rtl/rv64g_l1_bank_arbiter_rr.sv
// L1 bank arbiter: scalar port 0 has priority over vector lanes, except that a lane
// denied STARVE_LIMIT cycles in a row is force-granted. Bank command is registered.
module rv64g_l1_bank_arbiter_rr_wait #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic gnt,
  output logic starved
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt)              cnt_d = '0;
    else if (cnt_q != 8'(LIMIT))  cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  // A saturated count only matters while the lane is still asking.
  assign starved = req && (cnt_q == 8'(LIMIT));
endmodule

module rv64g_l1_bank_arbiter_rr #(
  parameter int NUM_PORTS    = 2,
  parameter int TAG_W        = 53,
  parameter int INDEX_W      = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic                         clk_i,
  input logic                         rst_i,
  rv64g_l1_bank_arbiter_rr_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_PORTS);

  logic                 bcast;
  logic [NUM_PORTS-1:0] starved, gnt;
  logic [SEL_W-1:0]     sel;
  logic                 forced, found;

  assign bcast = bus.tag_we_i & ~bus.req_i[0];

  assign starved[0] = 1'b0;
  for (genvar p = 1; p < NUM_PORTS; p++) begin : g_lane
    rv64g_l1_bank_arbiter_rr_wait #(.LIMIT(STARVE_LIMIT)) u_wait (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (bus.req_i[p]),
      .gnt     (gnt[p]),
      .starved (starved[p])
    );
  end

  always_comb begin
    gnt    = '0;
    sel    = '0;
    forced = 1'b0;
    found  = 1'b0;
    if (!rst_i && !bcast) begin
      for (int p = 1; p < NUM_PORTS; p++)
        if (starved[p] && !found) begin
          gnt[p] = 1'b1; sel = SEL_W'(p); found = 1'b1; forced = 1'b1;
        end
      if (!found && bus.req_i[0]) begin
        gnt[0] = 1'b1; found = 1'b1;
      end
      for (int p = 1; p < NUM_PORTS; p++)
        if (bus.req_i[p] && !found) begin
          gnt[p] = 1'b1; sel = SEL_W'(p); found = 1'b1;
        end
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.stall_o = bus.req_i & ~gnt;

  logic               bank_req_q, bank_req_d, bank_we_q, bank_we_d, bank_tag_we_q, bank_tag_we_d;
  logic [INDEX_W-1:0] bank_index_q, bank_index_d;
  logic [2:0]         bank_word_q, bank_word_d, bank_way_q, bank_way_d;
  logic [7:0]         bank_be_q, bank_be_d;
  logic [63:0]        bank_wdata_q, bank_wdata_d;
  logic [TAG_W-1:0]   bank_tag_q, bank_tag_d;
  logic [1:0]         bank_state_q, bank_state_d;
  logic [15:0]        starve_cnt_q, starve_cnt_d;

  always_comb begin
    bank_req_d    = 1'b0;
    bank_we_d     = 1'b0;
    bank_tag_we_d = 1'b0;
    bank_index_d  = bank_index_q;
    bank_word_d   = bank_word_q;
    bank_way_d    = bank_way_q;
    bank_be_d     = bank_be_q;
    bank_wdata_d  = bank_wdata_q;
    bank_tag_d    = bank_tag_q;
    bank_state_d  = bank_state_q;
    starve_cnt_d  = starve_cnt_q;
    // Broadcast leaves sel at 0, so the tag write uses the scalar port's index/way.
    if ((|gnt) || bcast) begin
      bank_req_d    = 1'b1;
      bank_we_d     = (|gnt) & bus.we_i[sel];
      bank_tag_we_d = bcast | (gnt[0] & bus.tag_we_i);
      bank_index_d  = bus.index_i[sel*INDEX_W +: INDEX_W];
      bank_word_d   = bus.word_i[sel*3 +: 3];
      bank_way_d    = bus.way_i[sel*3 +: 3];
      bank_be_d     = bus.be_i[sel*8 +: 8];
      bank_wdata_d  = bus.wdata_i[sel*64 +: 64];
      bank_tag_d    = (bcast | gnt[0]) ? bus.tag_i   : '0;
      bank_state_d  = (bcast | gnt[0]) ? bus.state_i : '0;
    end
    if (forced && starve_cnt_q != 16'hFFFF) starve_cnt_d = starve_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_req_q <= 1'b0; bank_we_q <= 1'b0; bank_tag_we_q <= 1'b0;
      bank_index_q <= '0; bank_word_q <= '0; bank_way_q <= '0; bank_be_q <= '0;
      bank_wdata_q <= '0; bank_tag_q <= '0; bank_state_q <= '0; starve_cnt_q <= '0;
    end else begin
      bank_req_q <= bank_req_d; bank_we_q <= bank_we_d; bank_tag_we_q <= bank_tag_we_d;
      bank_index_q <= bank_index_d; bank_word_q <= bank_word_d; bank_way_q <= bank_way_d;
      bank_be_q <= bank_be_d; bank_wdata_q <= bank_wdata_d; bank_tag_q <= bank_tag_d;
      bank_state_q <= bank_state_d; starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.bank_req_o    = bank_req_q;
  assign bus.bank_we_o     = bank_we_q;
  assign bus.bank_tag_we_o = bank_tag_we_q;
  assign bus.bank_index_o  = bank_index_q;
  assign bus.bank_word_o   = bank_word_q;
  assign bus.bank_way_o    = bank_way_q;
  assign bus.bank_be_o     = bank_be_q;
  assign bus.bank_wdata_o  = bank_wdata_q;
  assign bus.bank_tag_o    = bank_tag_q;
  assign bus.bank_state_o  = bank_state_q;
  assign bus.starve_cnt_o  = starve_cnt_q;
endmodule
